// File: rtl/regdst_pipe.sv
// regdst_pipe: EX/MEM and MEM/WB destination-tag pipeline with ALU forwarding selects,
// load-use stall detection and a saturating stall counter. Define REGDST_PIPE_FWD_EN to compile forwarding in.
module regdst_pipe (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  ex_dst,
  input  logic        ex_regwrite,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rs,
  input  logic [4:0]  ex_rt,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        flush,
  output logic [4:0]  mem_dst,
  output logic        mem_regwrite,
  output logic        mem_memread,
  output logic [4:0]  wb_dst,
  output logic        wb_regwrite,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic        stall,
  output logic [15:0] stall_count
);

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  logic [4:0]  r_mem_dst;
  logic        r_mem_regwrite;
  logic        r_mem_memread;
  logic [4:0]  r_wb_dst;
  logic        r_wb_regwrite;
  logic [15:0] r_stall_count;
  logic        w_stall;
  logic [1:0]  w_fwd_a;
  logic [1:0]  w_fwd_b;

  // A written, nonzero destination equal to src; register 0 never matches.
  function automatic logic tag_hit(input logic [4:0] dst, input logic wr, input logic [4:0] src);
    return wr && (dst != 5'd0) && (dst == src);
  endfunction

  function automatic logic id_reads(input logic [4:0] dst, input logic wr, input logic [4:0] rs,
                                    input logic [4:0] rt, input logic uses_rt);
    return tag_hit(dst, wr, rs) || (uses_rt && tag_hit(dst, wr, rt));
  endfunction

  // EX/MEM tag: flush squashes the EX instruction into a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_dst      <= 5'd0;
      r_mem_regwrite <= 1'b0;
      r_mem_memread  <= 1'b0;
    end else if (flush) begin
      r_mem_dst      <= 5'd0;
      r_mem_regwrite <= 1'b0;
      r_mem_memread  <= 1'b0;
    end else begin
      r_mem_dst      <= ex_dst;
      r_mem_regwrite <= ex_regwrite && (ex_dst != 5'd0);
      r_mem_memread  <= ex_memread;
    end
  end

  // MEM/WB tag advances every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_dst      <= 5'd0;
      r_wb_regwrite <= 1'b0;
    end else begin
      r_wb_dst      <= r_mem_dst;
      r_wb_regwrite <= r_mem_regwrite;
    end
  end

  // Saturating stall-cycle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_count <= 16'd0;
    end else if (w_stall && (r_stall_count != CNT_MAX)) begin
      r_stall_count <= r_stall_count + 16'd1;
    end else begin
      r_stall_count <= r_stall_count;
    end
  end

`ifdef REGDST_PIPE_FWD_EN
  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    logic [1:0] sel;
    if (tag_hit(r_mem_dst, r_mem_regwrite, src)) begin
      sel = 2'b10;
    end else if (tag_hit(r_wb_dst, r_wb_regwrite, src)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Operand forwarding; the younger EX/MEM result wins over MEM/WB
  always_comb begin
    w_fwd_a = fwd_sel(ex_rs);
    w_fwd_b = fwd_sel(ex_rt);
  end

  // Only a load in EX needs a bubble; everything else is forwarded
  always_comb begin
    w_stall = 1'b0;
    if (flush) begin
      w_stall = 1'b0;
    end else begin
      w_stall = ex_memread && id_reads(ex_dst, ex_regwrite, id_rs, id_rt, id_uses_rt);
    end
  end
`else
  logic w_unused_ok;
  assign w_unused_ok = ^{ex_rs, ex_rt, ex_memread};

  // Without forwarding, operands always come from the register file
  always_comb begin
    w_fwd_a = 2'b00;
    w_fwd_b = 2'b00;
  end

  // Any pending EX or MEM write to an ID source stalls; WB writes land before the read
  always_comb begin
    w_stall = 1'b0;
    if (flush) begin
      w_stall = 1'b0;
    end else begin
      w_stall = id_reads(ex_dst, ex_regwrite, id_rs, id_rt, id_uses_rt) ||
                id_reads(r_mem_dst, r_mem_regwrite, id_rs, id_rt, id_uses_rt);
    end
  end
`endif

  assign mem_dst      = r_mem_dst;
  assign mem_regwrite = r_mem_regwrite;
  assign mem_memread  = r_mem_memread;
  assign wb_dst       = r_wb_dst;
  assign wb_regwrite  = r_wb_regwrite;
  assign fwd_a        = w_fwd_a;
  assign fwd_b        = w_fwd_b;
  assign stall        = w_stall;
  assign stall_count  = r_stall_count;

endmodule
